// File: rtl/onchip_sram_stream_reader_pkg.sv
// Shared types and sizing for the on-chip SRAM stream reader.
// Word/address geometry lives here so the interfaces and the datapath agree.
package sram_rd_pkg;

    localparam int DATA_W       = 64;
    localparam int ADDR_W       = 6;
    localparam int FIFO_DEPTH   = 4;
    localparam int READ_LATENCY = 1;
    localparam int BE_W         = DATA_W / 8;
    localparam int LEN_W        = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/onchip_sram_stream_reader_if.sv
// Avalon-MM read port towards SRAM s2 and Avalon-ST source port towards the sink.
// Master modports belong to the reader; slave modports to the SRAM and the sink.
interface sram_rd_mem_if;
    import sram_rd_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write, byteenable, clken, input readdata);
    modport slave  (input address, chipselect, write, byteenable, clken, output readdata);
endinterface

interface sram_rd_st_if;
    import sram_rd_pkg::*;

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/onchip_sram_stream_reader_fifo.sv
// Synchronous output buffer between the SRAM read pipe and the stream port.
// Head entry is presented combinationally so it stays stable while not popped.
module sram_rd_fifo
    import sram_rd_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_push_data,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_head,
    output logic [clog2(DEPTH):0]     o_count,
    output logic                      o_empty,
    output logic                      o_full
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; r_count alone decides which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/onchip_sram_stream_reader.sv
// Avalon-MM read master that streams LENGTH words from the SRAM as one Avalon-ST packet.
// Reads are only issued while buffered plus in-flight words leave room in the FIFO.
module onchip_sram_stream_reader
    import sram_rd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_busy,
    output logic              o_done,
    sram_rd_mem_if.master     mem,
    sram_rd_st_if.master      st
);
    localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = 8;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cs;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [ADDR_W-1:0]       r_addr;
    logic [LEN_W-1:0]        r_issue_cnt;
    logic [LEN_W-1:0]        r_beat_cnt;
    logic                    r_first;
    logic [READ_LATENCY-1:0] r_pipe;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [DATA_W-1:0] w_fifo_head;
    logic              w_beat;
    logic              w_last_beat;
    logic [CRED_W-1:0] w_credit_used;
    logic              w_can_issue;

    // The read on the bus this cycle and every pipe stage each own a FIFO slot.
    assign w_credit_used = CRED_W'(w_fifo_count) + CRED_W'(r_cs) + CRED_W'($countones(r_pipe));
    assign w_can_issue   = (w_credit_used < CRED_W'(FIFO_DEPTH));
    assign w_beat        = ~w_fifo_empty & st.ready;
    assign w_last_beat   = (r_beat_cnt == LEN_W'(1));

    sram_rd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (r_pipe[READ_LATENCY-1]),
        .i_push_data (mem.readdata),
        .i_pop       (w_beat),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // NOTE: all state updates use non-blocking assignments; later ones in this block override earlier defaults.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cs        <= 1'b0;
            r_mem_addr  <= '0;
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_first     <= 1'b0;
            r_pipe      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cs      <= 1'b0;
            r_pipe[0] <= r_cs;
            for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];

            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt - 1'b1;
                r_first    <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_length != '0) begin
                            r_state     <= ISSUE;
                            r_busy      <= 1'b1;
                            r_addr      <= i_base_addr;
                            r_issue_cnt <= i_length;
                            r_beat_cnt  <= i_length;
                            r_first     <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_can_issue) begin
                        r_cs        <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_addr      <= r_addr + 1'b1;
                        r_issue_cnt <= r_issue_cnt - 1'b1;
                        if (r_issue_cnt == LEN_W'(1)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_beat && w_last_beat) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

    assign mem.address    = r_mem_addr;
    assign mem.chipselect = r_cs;
    assign mem.write      = 1'b0;
    assign mem.byteenable = '1;
    assign mem.clken      = 1'b1;

    assign st.data  = w_fifo_head;
    assign st.valid = ~w_fifo_empty;
    assign st.sop   = ~w_fifo_empty & r_first;
    assign st.eop   = ~w_fifo_empty & w_last_beat;

endmodule

// File: tb/tb_onchip_sram_stream_reader.sv
// Scoreboard bench: commands push expected beats/addresses, a negedge monitor pops and compares.
// Busy/done/credit behaviour is tracked by a small packet-level model inside the monitor.
module tb_onchip_sram_stream_reader;
    import sram_rd_pkg::*;

    localparam int MEM_WORDS = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy;
    logic              done;

    sram_rd_mem_if mem_if ();
    sram_rd_st_if  st_if ();

    onchip_sram_stream_reader dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_length    (length),
        .o_busy      (busy),
        .o_done      (done),
        .mem         (mem_if),
        .st          (st_if)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] sram [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_if.chipselect === 1'b1) mem_if.readdata <= sram[mem_if.address];
    end

    int ready_mode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       st_if.ready = 1'b1;
            1:       st_if.ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: st_if.ready = 1'($urandom_range(0, 1));
        endcase
    end

    int                n_checks = 0;
    int                n_fail = 0;
    beat_t             exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_true(input string name, input logic cond);
        n_checks++;
        if (cond !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: condition false (t=%0t)", name, $time);
        end
    endtask

    // Packet-level model: busy from an accepted non-empty start until the eop handshake,
    // done one cycle after the eop handshake or after a zero-length start.
    logic              exp_busy = 1'b0;
    logic              exp_done = 1'b0;
    int                issued = 0;
    int                accepted = 0;
    int                beats_seen = 0;
    logic              stalled = 1'b0;
    logic [DATA_W-1:0] stall_data;
    logic              stall_sop;
    logic              stall_eop;

    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            issued   = 0;
            accepted = 0;
            stalled  = 1'b0;
        end else begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (stalled) begin
                check("stall_valid", st_if.valid, 1'b1);
                check("stall_data", st_if.data, stall_data);
                check("stall_sop", st_if.sop, stall_sop);
                check("stall_eop", st_if.eop, stall_eop);
            end
            if (mem_if.chipselect) begin
                issued++;
                if (addr_q.size() == 0) check_true("unexpected_read", 1'b0);
                else check("rd_addr", mem_if.address, addr_q.pop_front());
                check_true("outstanding_le_depth", (issued - accepted) <= FIFO_DEPTH);
            end
            exp_done = 1'b0;
            if (start && !exp_busy) begin
                if (length != '0) exp_busy = 1'b1;
                else exp_done = 1'b1;
            end
            if (st_if.valid && st_if.ready) begin
                accepted++;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check_true("unexpected_beat", 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", st_if.data, b.data);
                    check("beat_sop", st_if.sop, b.sop);
                    check("beat_eop", st_if.eop, b.eop);
                    if (b.eop) begin
                        exp_busy = 1'b0;
                        exp_done = 1'b1;
                    end
                end
            end
            stalled = st_if.valid && !st_if.ready;
            if (stalled) begin
                stall_data = st_if.data;
                stall_sop  = st_if.sop;
                stall_eop  = st_if.eop;
            end
        end
    end

    task automatic run_cmd(input int b, input int len);
        beat_t e;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        length    = LEN_W'(len);
        for (int i = 0; i < len; i++) begin
            e.data = sram[(b + i) % MEM_WORDS];
            e.sop  = (i == 0);
            e.eop  = (i == len - 1);
            exp_q.push_back(e);
            addr_q.push_back(ADDR_W'((b + i) % MEM_WORDS));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_busy || exp_done) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) check_true("packet_timeout", 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_cs"}, mem_if.chipselect, 1'b0);
        check({tag, "_addr"}, mem_if.address, '0);
        check({tag, "_valid"}, st_if.valid, 1'b0);
        check({tag, "_sop"}, st_if.sop, 1'b0);
        check({tag, "_eop"}, st_if.eop, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < MEM_WORDS; i++) sram[i] = {$urandom, $urandom};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("tie_write", mem_if.write, 1'b0);
        check("tie_byteenable", mem_if.byteenable, {BE_W{1'b1}});
        check("tie_clken", mem_if.clken, 1'b1);
        reset = 1'b0;

        // Basic and wrap-around packets at full throughput
        ready_mode = 0;
        run_cmd(5, 4);
        wait_done(200);
        run_cmd(62, 4);
        wait_done(200);

        // Backpressure 1,0,0,1
        ready_mode = 1;
        run_cmd(7, 16);
        wait_done(500);

        // Zero length, full memory sweep
        ready_mode = 0;
        run_cmd(3, 0);
        wait_done(50);
        beats_seen = 0;
        run_cmd(10, 64);
        wait_done(1000);
        check("len64_beats", beats_seen, 64);

        // Start while busy is ignored
        beats_seen = 0;
        run_cmd(30, 8);
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = '0;
        length    = LEN_W'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);
        check("busy_start_beats", beats_seen, 8);

        // Reset after the third beat
        beats_seen = 0;
        run_cmd(20, 16);
        n = 0;
        while (beats_seen < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check_true("reset_wait_timeout", 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_cmd(0, 2);
        wait_done(200);

        // Randomised packets under random backpressure
        for (int k = 0; k < 8; k++) begin
            ready_mode = int'($urandom_range(0, 2));
            run_cmd(int'($urandom_range(0, MEM_WORDS - 1)), int'($urandom_range(1, MEM_WORDS)));
            wait_done(3000);
        end

        check("final_exp_q_empty", exp_q.size(), 0);
        check("final_addr_q_empty", addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
